// File: rtl/xadc_pkg.sv
// Shared constants, register map and state encodings for the XADC DRP responder.
package xadc_pkg;

   localparam logic [6:0]  ADDR_RES_BASE = 7'h00;
   localparam logic [6:0]  ADDR_CFG0     = 7'h40;
   localparam logic [6:0]  ADDR_CFG1     = 7'h41;
   localparam logic [6:0]  ADDR_CFG2     = 7'h42;

   localparam logic [3:0]  SEQ_SINGLE    = 4'b0011;

   localparam logic [15:0] CFG0_RST      = 16'h0000;
   localparam logic [15:0] CFG1_RST      = 16'h0000;
   localparam logic [15:0] CFG2_RST      = 16'h0400;

   typedef enum logic {D_IDLE, D_WAIT} drp_state_t;
   typedef enum logic [1:0] {C_IDLE, C_CFG, C_CONV, C_EOC} conv_state_t;

   // Result registers occupy 0x00-0x1F.
   function automatic logic is_result_addr(input logic [6:0] a);
      return (a & 7'h60) == ADDR_RES_BASE;
   endfunction

endpackage

// File: rtl/xadc_drp_responder_if.sv
// DRP bus plus event-mode conversion handshake between initiator and XADC stand-in.
interface xadc_drp_responder_if;
   logic        den;
   logic        dwe;
   logic [6:0]  daddr;
   logic [15:0] di;
   logic        drdy;
   logic [15:0] do_out;
   logic        convst;
   logic [11:0] sample_in;
   logic        busy_xadc;
   logic        eoc;
   logic        eos;
   logic [4:0]  channel;
   logic        protocol_err;

   modport master (
      output den, dwe, daddr, di, convst, sample_in,
      input  drdy, do_out, busy_xadc, eoc, eos, channel, protocol_err
   );

   modport slave (
      input  den, dwe, daddr, di, convst, sample_in,
      output drdy, do_out, busy_xadc, eoc, eos, channel, protocol_err
   );
endinterface

// File: rtl/xadc_drp_slave.sv
// DRP responder FSM with the config register bank and the result register file.
module xadc_drp_slave
   import xadc_pkg::*;
#(
   parameter int RD_LATENCY = 2
) (
   input  logic        clk125,
   input  logic        rst_n,
   input  logic        den,
   input  logic        dwe,
   input  logic [6:0]  daddr,
   input  logic [15:0] di,
   output logic        drdy,
   output logic [15:0] do_out,
   output logic        protocol_err,
   output logic        commit,
   output logic [6:0]  commit_addr,
   output logic [4:0]  commit_sel,
   output logic [4:0]  cfg_sel,
   output logic [3:0]  seq_mode,
   input  logic        res_we,
   input  logic [4:0]  res_idx,
   input  logic [15:0] res_data
);

   drp_state_t  d_state, d_next;
   logic [3:0]  lat_cnt;
   logic [6:0]  addr_q;
   logic        we_q;
   logic [15:0] di_q;
   logic [15:0] cfg0, cfg1, cfg2;
   logic [15:0] result [32];
   logic [15:0] rdata;

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         d_state <= D_IDLE;
         lat_cnt <= '0;
      end else begin
         d_state <= d_next;
         if (d_state == D_IDLE && den) lat_cnt <= 4'd1;
         else if (d_state == D_WAIT)   lat_cnt <= lat_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk125) begin
      if (d_state == D_IDLE && den) begin
         addr_q <= daddr;
         we_q   <= dwe;
         di_q   <= di;
      end
   end

   always_comb begin
      d_next       = d_state;
      drdy         = 1'b0;
      protocol_err = 1'b0;
      case (d_state)
         D_IDLE: if (den) d_next = D_WAIT;
         D_WAIT: begin
            protocol_err = den;
            if (lat_cnt == 4'(RD_LATENCY)) begin
               drdy   = 1'b1;
               d_next = D_IDLE;
            end
         end
         default: d_next = D_IDLE;
      endcase
   end

   assign commit      = drdy && we_q;
   assign commit_addr = addr_q;
   assign commit_sel  = di_q[4:0];
   assign cfg_sel     = cfg0[4:0];
   assign seq_mode    = cfg1[15:12];

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         cfg0 <= CFG0_RST;
         cfg1 <= CFG1_RST;
         cfg2 <= CFG2_RST;
      end else if (commit) begin
         case (addr_q)
            ADDR_CFG0: cfg0 <= di_q;
            ADDR_CFG1: cfg1 <= di_q;
            ADDR_CFG2: cfg2 <= di_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) result[i] <= '0;
      end else if (res_we) begin
         result[res_idx] <= res_data;
      end
   end

   // Combinational read: a result written on the EOC edge is seen only from the next cycle.
   always_comb begin
      rdata = '0;
      if (is_result_addr(addr_q)) begin
         rdata = result[addr_q[4:0]];
      end else begin
         case (addr_q)
            ADDR_CFG0: rdata = cfg0;
            ADDR_CFG1: rdata = cfg1;
            ADDR_CFG2: rdata = cfg2;
            default:   rdata = '0;
         endcase
      end
   end

   assign do_out = (drdy && !we_q) ? rdata : 16'h0000;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC stand-in: conversion FSM, delayed channel switch and DRP responder wiring.
module xadc_drp_responder
   import xadc_pkg::*;
#(
   parameter int RD_LATENCY      = 2,
   parameter int CONV_CYCLES     = 26,
   parameter int CFG_BUSY_CYCLES = 4,
   parameter int CH_SWITCH_LAG   = 1
) (
   input  logic                 clk125,
   input  logic                 rst_n,
   xadc_drp_responder_if.slave  bus
);

   logic        commit;
   logic [6:0]  commit_addr;
   logic [4:0]  commit_sel;
   logic [4:0]  cfg_sel;
   logic [3:0]  seq_mode;
   logic        res_we;

   conv_state_t c_state, c_next;
   logic [15:0] c_cnt;
   logic [11:0] sample_q;
   logic [4:0]  ch_q;
   logic [4:0]  channel_q;
   logic [4:0]  prev_sel;
   logic [7:0]  lag_cnt;
   logic [4:0]  eff_ch;
   logic        cfg_commit;
   logic        accept;
   logic        busy;

   xadc_drp_slave #(.RD_LATENCY(RD_LATENCY)) u_drp (
      .clk125       (clk125),
      .rst_n        (rst_n),
      .den          (bus.den),
      .dwe          (bus.dwe),
      .daddr        (bus.daddr),
      .di           (bus.di),
      .drdy         (bus.drdy),
      .do_out       (bus.do_out),
      .protocol_err (bus.protocol_err),
      .commit       (commit),
      .commit_addr  (commit_addr),
      .commit_sel   (commit_sel),
      .cfg_sel      (cfg_sel),
      .seq_mode     (seq_mode),
      .res_we       (res_we),
      .res_idx      (ch_q),
      .res_data     ({sample_q, 4'b0000})
   );

   assign cfg_commit = commit && (commit_addr == ADDR_CFG0 || commit_addr == ADDR_CFG1);
   assign eff_ch     = (lag_cnt != 8'd0) ? prev_sel : cfg_sel;

   // A config commit overrides every state, including the convst-acceptance path.
   always_comb begin
      c_next = c_state;
      accept = 1'b0;
      if (cfg_commit) begin
         c_next = C_CFG;
      end else begin
         case (c_state)
            C_IDLE: if (bus.convst && seq_mode == SEQ_SINGLE) begin
               accept = 1'b1;
               c_next = C_CONV;
            end
            C_CONV: if (c_cnt == 16'(CONV_CYCLES))     c_next = C_EOC;
            C_CFG:  if (c_cnt == 16'(CFG_BUSY_CYCLES)) c_next = C_IDLE;
            C_EOC:  c_next = C_IDLE;
            default: c_next = C_IDLE;
         endcase
      end
   end

   assign busy   = (c_state == C_CONV) || (c_state == C_CFG);
   assign res_we = (c_state == C_EOC);

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         c_state   <= C_IDLE;
         c_cnt     <= '0;
         channel_q <= '0;
         prev_sel  <= '0;
         lag_cnt   <= '0;
      end else begin
         c_state <= c_next;
         if (cfg_commit || accept) c_cnt <= 16'd1;
         else if (busy)            c_cnt <= c_cnt + 16'd1;
         if (c_state == C_CONV && c_next == C_EOC) channel_q <= ch_q;
         if (commit && commit_addr == ADDR_CFG0 && commit_sel != cfg_sel) begin
            prev_sel <= cfg_sel;
            lag_cnt  <= 8'(CH_SWITCH_LAG);
         end else if (accept && lag_cnt != 8'd0) begin
            lag_cnt  <= lag_cnt - 8'd1;
         end
      end
   end

   always_ff @(posedge clk125) begin
      if (accept) begin
         sample_q <= bus.sample_in;
         ch_q     <= eff_ch;
      end
   end

   assign bus.busy_xadc = busy;
   assign bus.eoc       = res_we;
   assign bus.eos       = res_we;
   assign bus.channel   = channel_q;

endmodule
